dff: RTL and testbench
======================

// Module: dff
// PURPOSE
//  - Parameterisable D flip-flop / register primitive for the datapath and control library.
//  - Captures d on rising clk, with an optional enable selected at elaboration.
//  - Asynchronous active-low reset to a programmable value.
//  - Used wherever a single registered stage is needed; the default width of 1 replaces
//    hand-written always blocks.
// PARAMETERS
//  USE_EN     0    1: en gates capture (q holds when en=0); 0: en ignored, q loads d every cycle
//  WIDTH      1    data width of d/q in bits (>=1)
//  RST_VAL    '0   value driven on q while reset is asserted (WIDTH bits)
// PORTS
//  clk   in   1      clock; all capture on rising edge
//  rst   in   1      asynchronous, active-low reset (rst=0 resets)
//  d     in   WIDTH  data input
//  en    in   1      load enable; functional only when USE_EN=1, must still be connected
//  q     out  WIDTH  registered output
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-low.
//  - Reset: when rst falls, q=RST_VAL immediately, without waiting for clk.
//    q stays RST_VAL while rst=0, regardless of clk, d and en.
//  - Reset release: the first capture occurs at the first rising clk with rst=1.
//    No synchroniser is in the block; the system must deassert rst synchronously.
//  - USE_EN=0: at each rising clk, q<=d. Latency is 1 cycle. en has no effect, including en=0.
//  - USE_EN=1: at a rising clk, if en=1 then q<=d, else q holds its value.
//    en is sampled on the same edge as d.
//  - Reset mid-operation: reset overrides en and d immediately.
//    Any pending capture is lost.
//  - Simultaneous rst fall and clk rise: reset wins, and q=RST_VAL.
//  - X/Z on en when USE_EN=1: q becomes X (no masking). X/Z on d propagates to q on capture.
//  - q never changes on the falling clk edge. Values are stable for checking at negedge.
//  - No combinational path from d or en to q.
// CONFIGURATION
//  - Macro DFF_ASSERTIONS_EN.
//  - Defined: the block compiles concurrent SVA and cover properties.
//    - q==RST_VAL while !rst.
//    - With rst high, q==$past(d) when USE_EN=0.
//    - q==$past(en)?$past(d):$past(q) when USE_EN=1.
//    - No X on q after reset release when d and en are known.
//    - Covers: en toggling while USE_EN=1; reset asserted mid-stream.
//  - Undefined: no assertion code. Synthesised logic is identical either way.
// STRUCTURE
//  - Package dff_pkg holds:
//    - DFF_DEFAULT_WIDTH=1, DFF_DEFAULT_RST_VAL=0;
//    - typedef enum logic {DFF_NO_EN=0, DFF_WITH_EN=1} dff_en_mode_e, used for USE_EN values.
//  - Single always_ff with posedge clk / negedge rst.
//    A generate block on USE_EN selects the enable path.
//  - Sub-module dff_sva holds the assertions. It is bound or instantiated only under
//    DFF_ASSERTIONS_EN.
// TESTING
//  - Check at negedge clk after every stimulus step. A free-running clk has a period of 2 units.
//  - Reset: rst=0, d=0, en=0, one cycle -> q==0. Also assert rst between clk edges -> q==0 at once.
//  - USE_EN=0: rst=1, en=1, d=1 -> q==1. Then d=0 -> q==0.
//    Then en=0 -> q==0. Then d=1 with en=0 -> q==1 (enable ignored).
//  - USE_EN=1: with en=1, d=1 -> q==1. Then en=0, d=0 -> q==1 (hold).
//    Then en=1 -> q==0.
//  - Mid-stream reset: q==1, then drop rst for half a cycle -> q==0 immediately.
//    Release rst -> q follows d from the next rising edge.
//  - Width/reset value: WIDTH=8, RST_VAL=8'hA5.
//    Reset -> q==8'hA5. Then d=8'h3C -> q==8'h3C after 1 cycle.
//  - Report pass/fail counts at end. Any mismatch fails the test.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared defaults and enable-mode encoding for the dff register primitive.
// Optional assertion build: DFF_ASSERTIONS_EN.
`timescale 1ns/1ps
package dff_pkg;

  localparam int DFF_DEFAULT_WIDTH   = 1;
  localparam int DFF_DEFAULT_RST_VAL = 0;

  typedef enum logic {
    DFF_NO_EN   = 1'b0,
    DFF_WITH_EN = 1'b1
  } dff_en_mode_e;

endpackage

// File: rtl/dff_sva.sv
// Checker for dff: reset value, capture/hold behaviour, X-freedom and covers.
// Only compiled when DFF_ASSERTIONS_EN is defined.
`timescale 1ns/1ps
`ifdef DFF_ASSERTIONS_EN
module dff_sva
  import dff_pkg::*;
#(
  parameter int unsigned      USE_EN  = 0,
  parameter int unsigned      WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_DEFAULT_RST_VAL)
) (
  input logic             clk,
  input logic             rst,
  input logic [WIDTH-1:0] d,
  input logic             en,
  input logic [WIDTH-1:0] q
);

  a_rst_val: assert property (
    @(posedge clk) !rst |-> q == RST_VAL);

  a_no_x: assert property (
    @(posedge clk) disable iff (!rst)
    $past(rst) && !$isunknown($past({d, en, q}))
    |-> !$isunknown(q));

  if (USE_EN == int'(DFF_WITH_EN)) begin : g_en
    a_cap: assert property (
      @(posedge clk) disable iff (!rst)
      $past(rst) |->
      q == ($past(en) ? $past(d) : $past(q)));

    c_en_tgl: cover property (
      @(posedge clk) rst && $changed(en));
  end else begin : g_no_en
    a_cap: assert property (
      @(posedge clk) disable iff (!rst)
      $past(rst) |-> q == $past(d));
  end

  c_mid_rst: cover property (
    @(posedge clk) rst ##1 !rst);

endmodule
`endif

// File: rtl/dff.sv
// Parameterisable D flip-flop with optional load enable and async
// active-low reset to RST_VAL. DFF_ASSERTIONS_EN attaches dff_sva.
`timescale 1ns/1ps
module dff
  import dff_pkg::*;
#(
  parameter int unsigned      USE_EN  = 0,
  parameter int unsigned      WIDTH   = DFF_DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = WIDTH'(DFF_DEFAULT_RST_VAL)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  if (USE_EN == int'(DFF_WITH_EN)) begin : g_en
    // Unknown en yields unknown next state rather than silently holding.
    always_comb begin
      q_d = 'x;
      case (en)
        1'b1:    q_d = d;
        1'b0:    q_d = q_q;
        default: q_d = 'x;
      endcase
    end
  end else begin : g_no_en
    logic unused_en;
    assign unused_en = en;
    assign q_d       = d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) q_q <= RST_VAL;
    else      q_q <= q_d;
  end

  assign q = q_q;

`ifdef DFF_ASSERTIONS_EN
  dff_sva #(
    .USE_EN  (USE_EN),
    .WIDTH   (WIDTH),
    .RST_VAL (RST_VAL)
  ) u_sva (
    .clk (clk),
    .rst (rst),
    .d   (d),
    .en  (en),
    .q   (q)
  );
`endif

endmodule

// File: tb/tb_dff.sv
// Directed bench for dff: plain, enabled and 8-bit/A5 reset variants.
// Checks at negedge; mid-cycle reset probes between edges.
`timescale 1ns/1ps
module tb_dff;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       d0  = 1'b0;
  logic       en0 = 1'b0;
  logic       d1  = 1'b0;
  logic       en1 = 1'b0;
  logic [7:0] d8  = 8'h00;
  logic       q0;
  logic       q1;
  logic [7:0] q8;

  int n_cmp = 0;
  int n_bad = 0;

  always #1 clk = ~clk;

  dff #(.USE_EN(0)) u_plain (
    .clk (clk), .rst (rst), .d (d0), .en (en0), .q (q0)
  );

  dff #(.USE_EN(1)) u_en (
    .clk (clk), .rst (rst), .d (d1), .en (en1), .q (q1)
  );

  dff #(.USE_EN(0), .WIDTH(8), .RST_VAL(8'hA5)) u_w8 (
    .clk (clk), .rst (rst), .d (d8), .en (1'b0), .q (q8)
  );

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    @(negedge clk);
    chk("rst_q0", {7'd0, q0}, 8'h00);
    chk("rst_q1", {7'd0, q1}, 8'h00);
    chk("rst_q8", q8, 8'hA5);

    rst = 1'b1; en0 = 1'b1; d0 = 1'b1;
    en1 = 1'b1; d1 = 1'b1; d8 = 8'h3C;
    @(negedge clk);
    chk("ne_d1", {7'd0, q0}, 8'h01);
    chk("en_d1", {7'd0, q1}, 8'h01);
    chk("w8_3c", q8, 8'h3C);

    d0 = 1'b0; en1 = 1'b0; d1 = 1'b0; d8 = 8'hFF;
    @(negedge clk);
    chk("ne_d0", {7'd0, q0}, 8'h00);
    chk("en_hold", {7'd0, q1}, 8'h01);
    chk("w8_ff", q8, 8'hFF);

    en0 = 1'b0; en1 = 1'b1;
    @(negedge clk);
    chk("ne_en0", {7'd0, q0}, 8'h00);
    chk("en_load0", {7'd0, q1}, 8'h00);

    d0 = 1'b1; d1 = 1'b1; d8 = 8'h3C;
    @(negedge clk);
    chk("ne_ignore_en", {7'd0, q0}, 8'h01);
    chk("en_load1", {7'd0, q1}, 8'h01);

    #0.5 rst = 1'b0;
    #0.1;
    chk("mid_q0", {7'd0, q0}, 8'h00);
    chk("mid_q1", {7'd0, q1}, 8'h00);
    chk("mid_q8", q8, 8'hA5);

    @(posedge clk);
    #0.5 rst = 1'b1;
    @(negedge clk);
    chk("rel_q0", {7'd0, q0}, 8'h00);
    chk("rel_q1", {7'd0, q1}, 8'h00);
    chk("rel_q8", q8, 8'hA5);

    @(negedge clk);
    chk("post_q0", {7'd0, q0}, 8'h01);
    chk("post_q1", {7'd0, q1}, 8'h01);
    chk("post_q8", q8, 8'h3C);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
